iq_release_arbiter: RTL and testbench
=====================================

Name: iq_release_arbiter

Overview:
- Sits between the wakeup pipeline register's release outputs and the issue-queue free list.
- Each cycle, up to ISSUE_WIDTH issue-queue entries may be released, but the free list has only FREE_PORTS write ports.
- The block compacts the release requests, buffers them in a circular FIFO and drains them at up to FREE_PORTS per cycle, oldest first.
- It raises a stall request to the scheduler before the FIFO can overflow.

Parameters:
- ISSUE_WIDTH, 4, number of release request slots (int + complex + mem).
- FREE_PORTS, 2, free-list write ports drained per cycle (1..ISSUE_WIDTH).
- DEPTH, 16, FIFO entries; power of two, must be >= 3*ISSUE_WIDTH.
- PTR_WIDTH, 4, issue-queue index width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- releaseEntry, input, ISSUE_WIDTH, per-slot release valid.
- releasePtr, input, ISSUE_WIDTH x PTR_WIDTH, per-slot IQ index to free.
- freeValid, output, FREE_PORTS, per-port free-list write valid.
- freePtr, output, FREE_PORTS x PTR_WIDTH, IQ index written to the free list.
- stallReq, output, 1, asks the scheduler to stop selecting.
- pendingCount, output, $clog2(DEPTH)+1, FIFO occupancy.
- drained, output, 1, FIFO empty and no input this cycle; used by the recovery manager for quiescence.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: head=0, tail=0, count=0. freeValid=0, stallReq=0, pendingCount=0, drained=1.
  - Reset mid-operation discards all pending releases; the IQ is reset in the same cycle.
- Compaction: valid request slots are packed in ascending slot index. Let n = popcount(releaseEntry), 0..ISSUE_WIDTH.
- Push: n packed entries are written at tail..tail+n-1 (mod DEPTH); tail += n.
- Pop: d = min(count, FREE_PORTS) oldest entries are presented on freePtr[0..d-1] with freeValid[0..d-1]=1. head += d.
  - The free list always accepts; there is no ready input.
- Push and pop in the same cycle: count_next = count + n - d. Push never writes a slot being popped in the same cycle, because DEPTH margin guarantees it.
- Latency without bypass: a request in cycle t appears on freeValid no earlier than t+1.
- Order: strictly oldest cycle first; within one cycle, lower slot index first.
- Wrap-around: head and tail are $clog2(DEPTH)-bit counters that wrap naturally. Count disambiguates full from empty.
- stallReq = (count > DEPTH - 2*ISSUE_WIDTH). It is driven from registered count only; no input-to-stallReq combinational path.
  - This threshold absorbs one in-flight cycle of n = ISSUE_WIDTH after assertion.
- Overflow (count_next > DEPTH) is illegal. Simulation assertion fires; in synthesis the excess entries are dropped and the count saturates at DEPTH.
- Recovery or flush has no effect: flushed ops still own IQ entries, so their releases are still freed.
- Inputs are ignored while rst is high.

Optional Feature:
- Macro: RSD_MARCH_IQ_RELEASE_BYPASS_EN.
- Defined: when count==0, up to FREE_PORTS compacted inputs drive freeValid/freePtr in the same cycle (zero latency). Only the remainder n-FREE_PORTS is pushed. When count>0, behaviour is identical to the undefined case, so ordering is preserved.
- Undefined: all requests pass through the FIFO, with a minimum latency of 1 cycle. There is no combinational path from releaseEntry to freeValid.

Decomposition:
- Add to SchedulerTypes: IQ_RELEASE_FREE_PORTS and IQ_RELEASE_FIFO_DEPTH constants, plus a typedef IqReleaseCountPath of width $clog2(DEPTH)+1. Reuse IssueQueueIndexPath for pointers.
- Sub-module iq_release_compactor: combinational prefix-popcount packer. Inputs are releaseEntry/releasePtr; outputs are packed pointers and n.
- The FIFO storage, counters and stallReq stay in the top module.

Test Plan:
- Reset, then idle: freeValid=00, stallReq=0, drained=1, pendingCount=0.
- One cycle with releaseEntry=1011, ptrs {3,7,x,9}, then idle (no bypass):
  - t+1: freePtr={3,7}, freeValid=11.
  - t+2: freePtr[0]=9, freeValid=01.
  - t+3: drained=1.
- Sustained releaseEntry=1111 for 4 cycles:
  - count goes 4,6,8,10.
  - stallReq asserts when count>8, i.e. visible in the cycle after count reaches 10.
  - No overflow assertion fires.
  - After inputs stop, count drains by 2 per cycle to 0.
- Wrap-around: fill and drain 40 entries with ptr = sequence mod 16. The freePtr output sequence exactly matches the input order across head/tail wrap.
- Reset asserted with count=7: next cycle count=0, freeValid=00, stallReq=0; a release in the same cycle as rst is discarded.
- With RSD_MARCH_IQ_RELEASE_BYPASS_EN and an empty FIFO:
  - releaseEntry=0111, ptrs {1,2,4}: same cycle freePtr={1,2}, freeValid=11.
  - Next cycle freePtr[0]=4.

Source files
------------

// File: rtl/iq_release_arbiter_pkg.sv
// Shared scheduler constants and types for the issue-queue release arbiter.
package iq_release_arbiter_pkg;

   localparam int IQ_RELEASE_ISSUE_WIDTH  = 4;
   localparam int IQ_RELEASE_FREE_PORTS   = 2;
   localparam int IQ_RELEASE_FIFO_DEPTH   = 16;
   localparam int ISSUE_QUEUE_INDEX_WIDTH = 4;

   typedef logic [ISSUE_QUEUE_INDEX_WIDTH-1:0]      IssueQueueIndexPath;
   typedef logic [$clog2(IQ_RELEASE_FIFO_DEPTH):0]  IqReleaseCountPath;

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/iq_release_arbiter_compactor.sv
// Packs the valid release slots into a dense list in ascending slot order and
// reports how many were valid. Purely combinational.
module iq_release_compactor
   import iq_release_arbiter_pkg::*;
#(
   parameter int ISSUE_WIDTH = IQ_RELEASE_ISSUE_WIDTH,
   parameter int PTR_WIDTH   = ISSUE_QUEUE_INDEX_WIDTH,
   parameter int CNT_W       = $clog2(ISSUE_WIDTH + 1)
) (
   input  logic [ISSUE_WIDTH-1:0]                releaseEntry,
   input  logic [ISSUE_WIDTH-1:0][PTR_WIDTH-1:0] releasePtr,
   output logic [ISSUE_WIDTH-1:0][PTR_WIDTH-1:0] packed_ptr,
   output logic [CNT_W-1:0]                      packed_count
);

   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_slot
         logic [PTR_WIDTH-1:0] sel_ptr;

         // Output slot gi takes the gi-th set request, counting from slot 0.
         always_comb begin
            int seen;
            sel_ptr = '0;
            seen    = 0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
               if (releaseEntry[i]) begin
                  if (seen == gi) sel_ptr = releasePtr[i];
                  seen = seen + 1;
               end
            end
         end

         assign packed_ptr[gi] = sel_ptr;
      end
   endgenerate

   always_comb begin
      packed_count = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         packed_count = packed_count + CNT_W'(releaseEntry[i]);
      end
   end

endmodule

// File: rtl/iq_release_arbiter.sv
// Compacts IQ release requests into a circular FIFO and drains them to the free
// list oldest first. Optional same-cycle bypass: RSD_MARCH_IQ_RELEASE_BYPASS_EN.
module iq_release_arbiter
   import iq_release_arbiter_pkg::*;
#(
   parameter int ISSUE_WIDTH = IQ_RELEASE_ISSUE_WIDTH,
   parameter int FREE_PORTS  = IQ_RELEASE_FREE_PORTS,
   parameter int DEPTH       = IQ_RELEASE_FIFO_DEPTH,
   parameter int PTR_WIDTH   = ISSUE_QUEUE_INDEX_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ISSUE_WIDTH-1:0]                releaseEntry,
   input  logic [ISSUE_WIDTH-1:0][PTR_WIDTH-1:0] releasePtr,
   output logic [FREE_PORTS-1:0]                 freeValid,
   output logic [FREE_PORTS-1:0][PTR_WIDTH-1:0]  freePtr,
   output logic                                  stallReq,
   output logic [$clog2(DEPTH):0]                pendingCount,
   output logic                                  drained
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int NW    = $clog2(ISSUE_WIDTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] PORTS_CNT   = CNT_W'(FREE_PORTS);
   localparam logic [CNT_W-1:0] STALL_LEVEL = CNT_W'(DEPTH - 2 * ISSUE_WIDTH);

   logic [ISSUE_WIDTH-1:0]                entry_eff;
   logic [ISSUE_WIDTH-1:0][PTR_WIDTH-1:0] pk_ptr;
   logic [NW-1:0]                         pk_n;
   logic [ISSUE_WIDTH-1:0][PTR_WIDTH-1:0] push_ptr;

   logic [IDX_W-1:0] head_reg, head_next;
   logic [IDX_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [CNT_W-1:0] pop_n, byp_n, push_req, push_n, space;

   logic [PTR_WIDTH-1:0] fifo_mem [DEPTH];

   // Requests arriving with reset are discarded along with the IQ contents.
   assign entry_eff = rst ? '0 : releaseEntry;

   iq_release_compactor #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .PTR_WIDTH   (PTR_WIDTH),
      .CNT_W       (NW)
   ) u_compactor (
      .releaseEntry (entry_eff),
      .releasePtr   (releasePtr),
      .packed_ptr   (pk_ptr),
      .packed_count (pk_n)
   );

   assign pop_n = (count_reg < PORTS_CNT) ? count_reg : PORTS_CNT;

`ifdef RSD_MARCH_IQ_RELEASE_BYPASS_EN
   assign byp_n = (count_reg != '0) ? '0 :
                  ((CNT_W'(pk_n) < PORTS_CNT) ? CNT_W'(pk_n) : PORTS_CNT);
`else
   assign byp_n = '0;
`endif

   assign push_req = CNT_W'(pk_n) - byp_n;
   assign space    = DEPTH_CNT - count_reg + pop_n;
   // Excess beyond the free space is dropped so the count saturates at DEPTH.
   assign push_n   = (push_req > space) ? space : push_req;

   assign count_next = count_reg + push_n - pop_n;
   assign head_next  = head_reg + IDX_W'(pop_n);
   assign tail_next  = tail_reg + IDX_W'(push_n);

   // Entries already sent through the bypass are skipped when writing the FIFO.
   always_comb begin
      push_ptr = '0;
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         if (j + int'(byp_n) < ISSUE_WIDTH) push_ptr[j] = pk_ptr[j + int'(byp_n)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         if (CNT_W'(j) < push_n) fifo_mem[tail_reg + IDX_W'(j)] <= push_ptr[j];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < FREE_PORTS; gi++) begin : g_port
`ifdef RSD_MARCH_IQ_RELEASE_BYPASS_EN
         assign freeValid[gi] = !rst && ((CNT_W'(gi) < pop_n) || (CNT_W'(gi) < byp_n));
         assign freePtr[gi]   = (count_reg == '0) ? pk_ptr[gi] : fifo_mem[head_reg + IDX_W'(gi)];
`else
         assign freeValid[gi] = !rst && (CNT_W'(gi) < pop_n);
         assign freePtr[gi]   = fifo_mem[head_reg + IDX_W'(gi)];
`endif
      end
   endgenerate

   // Registered count only, so the scheduler sees no input-dependent path.
   assign stallReq     = (count_reg > STALL_LEVEL);
   assign pendingCount = count_reg;
   assign drained      = (count_reg == '0) && (entry_eff == '0);

   overflow_chk: assert property (@(posedge clk) disable iff (rst) push_req <= space);

endmodule

// File: tb/tb_iq_release_arbiter.sv
// Randomized scoreboard bench for iq_release_arbiter against a queue-based model.
module tb_iq_release_arbiter;

   localparam int IW    = 4;
   localparam int FP    = 2;
   localparam int DEPTH = 16;
   localparam int PW    = 4;

   logic                   clk;
   logic                   rst;
   logic [IW-1:0]          releaseEntry;
   logic [IW-1:0][PW-1:0]  releasePtr;
   logic [FP-1:0]          freeValid;
   logic [FP-1:0][PW-1:0]  freePtr;
   logic                   stallReq;
   logic [$clog2(DEPTH):0] pendingCount;
   logic                   drained;

   iq_release_arbiter #(
      .ISSUE_WIDTH (IW),
      .FREE_PORTS  (FP),
      .DEPTH       (DEPTH),
      .PTR_WIDTH   (PW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .releaseEntry (releaseEntry),
      .releasePtr   (releasePtr),
      .freeValid    (freeValid),
      .freePtr      (freePtr),
      .stallReq     (stallReq),
      .pendingCount (pendingCount),
      .drained      (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int nvalid;
      int count;
      bit stall;
      bit drained;
   } cyc_t;

   cyc_t exp_cyc_q[$];
   int   exp_ptr_q[$];
   int   fifo_q[$];
   int   checks = 0;
   int   fails  = 0;
   bit   bypass_mode;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Apply one cycle of stimulus and record what the DUT must show in that cycle.
   task automatic drive(input bit r, input logic [IW-1:0] e, input logic [IW-1:0][PW-1:0] p);
      cyc_t c;
      int   inq[$];
      @(negedge clk);
      rst          = r;
      releaseEntry = e;
      releasePtr   = p;
      c.count = fifo_q.size();
      c.stall = (c.count > DEPTH - 2 * IW);
      if (r) begin
         c.nvalid  = 0;
         c.drained = (c.count == 0);
         fifo_q.delete();
      end else begin
         for (int i = 0; i < IW; i++) if (e[i]) inq.push_back(int'(p[i]));
         c.drained = (c.count == 0) && (inq.size() == 0);
         if (bypass_mode && fifo_q.size() == 0) begin
            c.nvalid = imin(inq.size(), FP);
            for (int k = 0; k < c.nvalid; k++) exp_ptr_q.push_back(inq.pop_front());
         end else begin
            c.nvalid = imin(fifo_q.size(), FP);
            for (int k = 0; k < c.nvalid; k++) exp_ptr_q.push_back(fifo_q.pop_front());
         end
         foreach (inq[i]) fifo_q.push_back(inq[i]);
      end
      exp_cyc_q.push_back(c);
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b0, '0, '0);
   endtask

   // Monitor: compares every cycle's outputs against the recorded expectations.
   initial begin
      cyc_t c;
      forever begin
         @(negedge clk);
         #1;
         if (exp_cyc_q.size() != 0) begin
            c = exp_cyc_q.pop_front();
            check("freeValid", int'(freeValid), (1 << c.nvalid) - 1);
            check("pendingCount", int'(pendingCount), c.count);
            check("stallReq", int'(stallReq), int'(c.stall));
            check("drained", int'(drained), int'(c.drained));
            for (int k = 0; k < FP; k++) begin
               if (k < c.nvalid) begin
                  if (exp_ptr_q.size() == 0) begin
                     check("ptr_queue_underflow", 1, 0);
                  end else begin
                     check("freePtr", int'(freePtr[k]), exp_ptr_q.pop_front());
                     $display("free port%0d ptr=%0d count=%0d t=%0t", k, freePtr[k], pendingCount, $time);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [IW-1:0][PW-1:0] p;
      logic [IW-1:0]         e;
      int                    seq;
      int                    guard;
`ifdef RSD_MARCH_IQ_RELEASE_BYPASS_EN
      bypass_mode = 1'b1;
`else
      bypass_mode = 1'b0;
`endif
      rst          = 1'b1;
      releaseEntry = '0;
      releasePtr   = '0;

      drive(1'b1, '0, '0);
      drive(1'b1, '0, '0);
      idle(2);

      // Sparse request: slots 0,1,3 carry 3,7,9.
      p = '0; p[0] = 4'd3; p[1] = 4'd7; p[3] = 4'd9;
      drive(1'b0, 4'b1011, p);
      idle(3);

      // Sustained full-width requests push the count into the stall region.
      for (int i = 0; i < 4; i++) drive(1'b0, 4'b1111, 16'($urandom));
      idle(8);

      // 40 sequential pointers across several head/tail wraps.
      seq = 0;
      while (seq < 40) begin
         if (fifo_q.size() > DEPTH - 2 * IW) begin
            idle(1);
         end else begin
            for (int i = 0; i < IW; i++) p[i] = PW'((seq + i) % 16);
            drive(1'b0, 4'b1111, p);
            seq += IW;
         end
      end
      idle(12);

      // Build occupancy, then reset with a request in the same cycle.
      drive(1'b0, 4'b1111, 16'($urandom));
      drive(1'b0, 4'b1111, 16'($urandom));
      drive(1'b0, 4'b0111, 16'($urandom));
      drive(1'b1, 4'b1111, 16'($urandom));
      idle(3);

      // Empty FIFO then a three-entry request.
      guard = 0;
      while (fifo_q.size() != 0 && guard < 20) begin
         idle(1);
         guard++;
      end
      p = '0; p[0] = 4'd1; p[1] = 4'd2; p[2] = 4'd4;
      drive(1'b0, 4'b0111, p);
      idle(3);

      // Random traffic honouring stallReq, with occasional resets.
      for (int i = 0; i < 400; i++) begin
         e = IW'($urandom);
         if (fifo_q.size() > DEPTH - 2 * IW) e = '0;
         drive($urandom_range(0, 49) == 0, e, 16'($urandom));
      end
      idle(14);

      @(negedge clk);
      #2;
      check("leftover_expected_ptrs", exp_ptr_q.size(), 0);
      check("leftover_cycle_records", exp_cyc_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
